fetch_insn_queue: RTL and testbench
===================================

Name: fetch_insn_queue

Overview:
- Instruction queue sitting between the fetch stage and the RISC-V decoder.
- Buffers fetched instructions together with their branch-prediction metadata.
- Presents them in program order to decode over a valid/ready handshake.
- It is the transmitting end of the decoder's input interface (insn, pc, insn_pred, pht_idx, insn_pred_target), and supports a pipeline flush on redirect.

Parameters:
LG_DEPTH, 3, log2 of entry count (DEPTH = 2^LG_DEPTH = 8 entries).
AF_SLACK, 2, almost_full asserts when occupancy >= DEPTH - AF_SLACK.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  discard all entries (redirect/mispredict), synchronous.
in_valid  input  1  fetch presents an entry.
in_ready  output  1  queue can accept (not full).
in_insn  input  32  instruction word.
in_pc  input  `M_WIDTH  instruction PC.
in_pred  input  1  predicted-taken bit.
in_pht_idx  input  `LG_PHT_SZ  PHT index used for prediction.
in_pred_target  input  `M_WIDTH  predicted target.
out_valid  output  1  head entry valid for decode.
out_ready  input  1  decode accepts head entry.
out_insn  output  32  head instruction.
out_pc  output  `M_WIDTH  head PC.
out_pred  output  1  head predicted-taken bit.
out_pht_idx  output  `LG_PHT_SZ  head PHT index.
out_pred_target  output  `M_WIDTH  head predicted target.
almost_full  output  1  occupancy >= DEPTH - AF_SLACK.
occupancy  output  LG_DEPTH+1  current entry count, 0..DEPTH.

Behaviour:
- Storage and pointers:
  - Circular array of DEPTH entries.
  - Head and tail pointers are LG_DEPTH+1 bits; the MSB is the wrap bit.
  - Empty when head==tail. Full when the low bits are equal and the wrap bits differ.
- Reset (async, active-high):
  - head=tail=0, so occupancy=0, out_valid=0, in_ready=1, almost_full=0.
  - All out_* data fields read 0. The storage array is not reset.
- Push and pop:
  - Push = in_valid & in_ready. Entry is written at tail and tail increments.
  - Pop = out_valid & out_ready. head increments.
  - Pointer wrap-around is the natural binary rollover of the LG_DEPTH+1-bit counters.
- Ready/valid generation:
  - in_ready = !full, derived from registered state only. It never depends on out_ready, so there is no combinational ready path.
  - A full queue refuses a push even when a pop occurs in the same cycle. in_ready rises the cycle after the pop.
  - out_valid = !empty.
  - Output data is read combinationally from the head entry. All out_* fields are forced to 0 when empty.
  - A head entry with out_valid=1 and out_ready=0 holds stable until popped or flushed.
- Latency: a push into an empty queue is visible at out_valid the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop when neither full nor empty: both take effect; occupancy is unchanged.
- Flush:
  - Next edge sets head=tail=0.
  - Flush has priority over push and pop in the same cycle: the push is dropped and the pop is not counted.
  - The cycle after flush: out_valid=0, occupancy=0, in_ready=1.
  - in_ready and out_valid during the flush cycle itself reflect the pre-flush state. Fetch must treat any handshake in that cycle as void.
- Status outputs:
  - occupancy = tail - head, modulo 2^(LG_DEPTH+1).
  - almost_full is combinational from occupancy.
- Reset asserted mid-operation: the queue immediately (asynchronously) shows the empty state. Prior contents are lost.

Test Plan:
- Reset, then push insns 0x00000013, 0x00100093, 0x00200113 at PCs 0x1000/0x1004/0x1008 with out_ready=0, then raise out_ready. Required: out_valid rises 1 cycle after the first push; pops return the insns in order with matching pc, pred, pht_idx and pred_target; occupancy steps 1,2,3,2,1,0.
- Push 8 entries with out_ready=0. Required: in_ready=0 and occupancy=8 after the 8th push; almost_full=1 from occupancy 6; a 9th in_valid is not accepted. Pop once: in_ready=1 the next cycle.
- Hold occupancy at 4 with in_valid=out_ready=1 for 20 cycles using PCs 0x2000+4k. Required: occupancy stays 4 throughout; head/tail wrap at least twice; output PC sequence is contiguous with no drop or duplicate.
- Occupancy 5; assert flush with in_valid=1 and out_ready=1 in the same cycle. Required next cycle: occupancy=0, out_valid=0, in_ready=1, out_pc=0; the flushed-cycle push never appears at the output.
- Occupancy 3; assert reset asynchronously mid-cycle. Required: out_valid=0, occupancy=0, in_ready=1 before the next clock edge. After release, one push (insn 0xdeadbeef) emerges alone.
- Full queue with in_valid=1 and out_ready=1 in the same cycle. Required: exactly one pop, no push; occupancy 7 next cycle; the refused entry is accepted one cycle later.

Source files
------------

// File: rtl/fetch_insn_queue.sv
// Instruction queue between fetch and decode: buffers fetched instructions with
// their branch-prediction metadata and presents them in program order.

`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 10
`endif

module fetch_insn_queue #(
  parameter int unsigned LG_DEPTH = 3,
  parameter int unsigned AF_SLACK = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_insn,
  input  logic [`M_WIDTH-1:0]     in_pc,
  input  logic                    in_pred,
  input  logic [`LG_PHT_SZ-1:0]   in_pht_idx,
  input  logic [`M_WIDTH-1:0]     in_pred_target,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_insn,
  output logic [`M_WIDTH-1:0]     out_pc,
  output logic                    out_pred,
  output logic [`LG_PHT_SZ-1:0]   out_pht_idx,
  output logic [`M_WIDTH-1:0]     out_pred_target,
  output logic                    almost_full,
  output logic [LG_DEPTH:0]       occupancy
);

  localparam int unsigned DEPTH  = 1 << LG_DEPTH;
  localparam int unsigned PTR_W  = LG_DEPTH + 1;
  localparam int unsigned AF_LVL = DEPTH - AF_SLACK;

  typedef struct packed {
    logic [31:0]           insn;
    logic [`M_WIDTH-1:0]   pc;
    logic                  pred;
    logic [`LG_PHT_SZ-1:0] pht_idx;
    logic [`M_WIDTH-1:0]   pred_target;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  entry_t             wr_entry;
  entry_t             head_entry;

  // Full/empty come from registered pointers only, so in_ready never sees out_ready.
  assign empty = (head == tail);
  assign full  = (head[LG_DEPTH-1:0] == tail[LG_DEPTH-1:0]) &&
                 (head[LG_DEPTH] != tail[LG_DEPTH]);

  assign in_ready  = !full;
  assign out_valid = !empty;

  // Flush voids any handshake that coincides with it.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  assign wr_entry = '{insn:        in_insn,
                      pc:          in_pc,
                      pred:        in_pred,
                      pht_idx:     in_pht_idx,
                      pred_target: in_pred_target};

  // Pointer state; the wrap bit rolls over naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
    end
  end

  // Storage is not reset; contents past the pointers are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[tail[LG_DEPTH-1:0]] <= wr_entry;
  end

  // Head read is masked to zero while empty so stale storage never leaks out.
  always_comb begin
    head_entry = '0;
    if (!empty) head_entry = mem[head[LG_DEPTH-1:0]];
  end

  assign out_insn        = head_entry.insn;
  assign out_pc          = head_entry.pc;
  assign out_pred        = head_entry.pred;
  assign out_pht_idx     = head_entry.pht_idx;
  assign out_pred_target = head_entry.pred_target;

  assign occupancy   = tail - head;
  assign almost_full = (occupancy >= PTR_W'(AF_LVL));

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Directed self-checking bench for fetch_insn_queue.

`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 10
`endif

module tb_fetch_insn_queue;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_insn;
  logic [`M_WIDTH-1:0]   in_pc;
  logic                  in_pred;
  logic [`LG_PHT_SZ-1:0] in_pht_idx;
  logic [`M_WIDTH-1:0]   in_pred_target;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_insn;
  logic [`M_WIDTH-1:0]   out_pc;
  logic                  out_pred;
  logic [`LG_PHT_SZ-1:0] out_pht_idx;
  logic [`M_WIDTH-1:0]   out_pred_target;
  logic                  almost_full;
  logic [3:0]            occupancy;

  int checks = 0;
  int errors = 0;

  fetch_insn_queue #(.LG_DEPTH(3), .AF_SLACK(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
    .in_pred(in_pred), .in_pht_idx(in_pht_idx), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc),
    .out_pred(out_pred), .out_pht_idx(out_pht_idx), .out_pred_target(out_pred_target),
    .almost_full(almost_full), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                       input logic pred, input int pht, input logic [31:0] tgt);
    in_valid       = v;
    in_insn        = insn;
    in_pc          = `M_WIDTH'(pc);
    in_pred        = pred;
    in_pht_idx     = `LG_PHT_SZ'(pht);
    in_pred_target = `M_WIDTH'(tgt);
  endtask

  logic [31:0] t1_insn [3];
  int np;
  int nq;

  initial begin
    t1_insn[0] = 32'h00000013;
    t1_insn[1] = 32'h00100093;
    t1_insn[2] = 32'h00200113;

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    tick(); tick();
    @(negedge clk); reset = 1'b0;
    tick();

    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_insn", 64'(out_insn), 64'd0);

    // In-order delivery with metadata
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, t1_insn[k], 32'h1000 + 32'(4 * k), k[0], k + 1, 32'h3000 + 32'(16 * k));
      if (k == 0) chk("t1_no_bypass", 64'(out_valid), 64'd0);
      tick();
      chk("t1_fill_occ", 64'(occupancy), 64'(k + 1));
      chk("t1_fill_valid", 64'(out_valid), 64'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t1_insn", 64'(out_insn), 64'(t1_insn[k]));
      chk("t1_pc", 64'(out_pc), 64'h1000 + 64'(4 * k));
      chk("t1_pred", 64'(out_pred), 64'(k[0]));
      chk("t1_pht", 64'(out_pht_idx), 64'(k + 1));
      chk("t1_tgt", 64'(out_pred_target), 64'h3000 + 64'(16 * k));
      tick();
      chk("t1_drain_occ", 64'(occupancy), 64'(2 - k));
    end
    chk("t1_empty_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Fill to full, refusal, and ready recovery
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h13, 32'h100 + 32'(4 * k), 1'b0, 0, 32'h0);
      tick();
      chk("t2_occ", 64'(occupancy), 64'(k + 1));
      chk("t2_af", 64'(almost_full), (k + 1 >= 6) ? 64'd1 : 64'd0);
    end
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h13, 32'h999, 1'b0, 0, 32'h0);
    tick();
    chk("t2_ninth_occ", 64'(occupancy), 64'd8);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_pop_occ", 64'(occupancy), 64'd7);
    chk("t2_pop_ready", 64'(in_ready), 64'd1);

    // Full queue with push and pop together: only the pop happens
    drive(1'b1, 32'h13, 32'h500, 1'b0, 0, 32'h0);
    tick();
    chk("t6_refill_occ", 64'(occupancy), 64'd8);
    drive(1'b1, 32'h13, 32'h504, 1'b0, 0, 32'h0);
    out_ready = 1'b1;
    chk("t6_head_pc", 64'(out_pc), 64'h104);
    tick();
    chk("t6_occ7", 64'(occupancy), 64'd7);
    chk("t6_ready", 64'(in_ready), 64'd1);
    chk("t6_next_pc", 64'(out_pc), 64'h108);
    out_ready = 1'b0;
    tick();
    chk("t6_accept_occ", 64'(occupancy), 64'd8);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t6_drain_pc", 64'(out_pc), (k < 6) ? 64'h108 + 64'(4 * k) : 64'h500 + 64'(4 * (k - 6)));
      tick();
    end
    chk("t6_drained_occ", 64'(occupancy), 64'd0);
    out_ready = 1'b0;

    // Steady state at occupancy 4 across several pointer wraps
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h13, 32'h2000 + 32'(4 * k), 1'b0, 0, 32'h0);
      tick();
    end
    np = 4;
    nq = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 32'h13, 32'h2000 + 32'(4 * np), 1'b0, 0, 32'h0);
      chk("t3_occ", 64'(occupancy), 64'd4);
      chk("t3_pc", 64'(out_pc), 64'h2000 + 64'(4 * nq));
      tick();
      np++;
      nq++;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("t3_tail_pc", 64'(out_pc), 64'h2000 + 64'(4 * nq));
      tick();
      nq++;
    end
    chk("t3_end_occ", 64'(occupancy), 64'd0);
    out_ready = 1'b0;

    // Flush beats a coincident push and pop
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h13, 32'h4000 + 32'(4 * k), 1'b0, 0, 32'h0);
      tick();
    end
    chk("t4_occ5", 64'(occupancy), 64'd5);
    drive(1'b1, 32'h13, 32'h4444, 1'b0, 0, 32'h0);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    chk("t4_occ", 64'(occupancy), 64'd0);
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_ready", 64'(in_ready), 64'd1);
    chk("t4_pc", 64'(out_pc), 64'd0);
    tick();
    chk("t4_no_ghost", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-cycle
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h13, 32'h5000 + 32'(4 * k), 1'b0, 0, 32'h0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    chk("t5_occ3", 64'(occupancy), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_occ", 64'(occupancy), 64'd0);
    chk("t5_async_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    drive(1'b1, 32'hdeadbeef, 32'h6000, 1'b0, 0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    chk("t5_insn", 64'(out_insn), 64'hdeadbeef);
    chk("t5_occ1", 64'(occupancy), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_alone_valid", 64'(out_valid), 64'd0);
    chk("t5_alone_occ", 64'(occupancy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
